wts_channel_scheduler: RTL and testbench

- Time-multiplexes one combinational tone generator and one wave-memory read port across NUM_CH channels.
- Holds each channel's 7-bit wave address and 12-bit frequency counter, and presents them with that channel's config to the shared tone generator.
- Writes the generator results back, fetches the wave sample, and latches it per channel.
- Arbitrates the wave-memory port between the channel sweep and CPU accesses.

---
 rtl/wts_channel_scheduler.sv | 192 +++++++++++++++++++
 tb/tb_wts_channel_scheduler.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/wts_channel_scheduler.sv
`default_nettype none
// ============================================================================
//  Module      : wts_channel_scheduler
//  Description : Time-multiplexes one combinational tone generator and one
//                wave-memory read port across NUM_CH channels. Each channel
//                gets a two-cycle slot: ACCESS (generator evaluation, state
//                write-back, memory read issue) then DATA (sample capture,
//                memory port free for the CPU).
//  Ports       :
//    clk, nreset                 clock, asynchronous active-low reset
//    enable                      sweep run (0 freezes phase/slot/state)
//    reg_key_on/_wave_length/
//    reg_frequency_count         per-channel configuration (packed by channel)
//    tg_reg_*, tg_*_in           current slot's config and state to generator
//    tg_*_out, tg_wave_address,
//    tg_half_timing              generator results for the current slot
//    mem_address/rd/we, rdata    shared wave-memory port
//    cpu_req/we/address, cpu_ack CPU access request and combinational grant
//    ch_sample, ch_half          latched samples, half-timing pulses
//    frame_end                   pulse after the last slot's DATA phase
//  Revision    : 1.0 - initial release
// ============================================================================
module wts_channel_scheduler #(
    parameter int NUM_CH  = 5,
    parameter int CH_BITS = 3
) (
    input  logic                      clk,
    input  logic                      nreset,
    input  logic                      enable,
    input  logic [NUM_CH-1:0]         reg_key_on,
    input  logic [2*NUM_CH-1:0]       reg_wave_length,
    input  logic [12*NUM_CH-1:0]      reg_frequency_count,
    output logic [1:0]                tg_reg_wave_length,
    output logic [11:0]               tg_reg_frequency_count,
    output logic [6:0]                tg_wave_address_in,
    output logic [11:0]               tg_frequency_count_in,
    input  logic [6:0]                tg_wave_address_out,
    input  logic [11:0]               tg_frequency_count_out,
    input  logic [6:0]                tg_wave_address,
    input  logic                      tg_half_timing,
    output logic [CH_BITS+6:0]        mem_address,
    output logic                      mem_rd,
    output logic                      mem_we,
    input  logic [7:0]                mem_rdata,
    input  logic                      cpu_req,
    input  logic                      cpu_we,
    input  logic [CH_BITS+6:0]        cpu_address,
    output logic                      cpu_ack,
    output logic [8*NUM_CH-1:0]       ch_sample,
    output logic [NUM_CH-1:0]         ch_half,
    output logic                      frame_end
);

    typedef enum logic [0:0] {
        PH_ACCESS = 1'b0,
        PH_DATA   = 1'b1
    } phase_t;

    localparam logic [CH_BITS-1:0] LAST_SLOT = CH_BITS'(NUM_CH - 1);

    phase_t               phase;
    phase_t               phase_next;
    logic [CH_BITS-1:0]   slot;
    logic [CH_BITS-1:0]   slot_next;
    logic                 frame_end_next;
    logic                 cpu_grant;

    // Per-channel state flattened so the slot mux can index it.
    logic [7*NUM_CH-1:0]  addr_flat;
    logic [12*NUM_CH-1:0] cnt_flat;

    // ------------------------------------------------------------------------
    // Sequencer: state register
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            phase     <= PH_ACCESS;
            slot      <= '0;
            frame_end <= 1'b0;
        end else begin
            phase     <= phase_next;
            slot      <= slot_next;
            frame_end <= frame_end_next;
        end
    end

    // The CPU owns the memory port whenever the sweep is not reading it:
    // every DATA phase while running, every cycle while frozen.
    assign cpu_grant = cpu_req && (!enable || (phase == PH_DATA));

    // ------------------------------------------------------------------------
    // Sequencer: next state and memory-port outputs
    // ------------------------------------------------------------------------
    always_comb begin
        phase_next     = phase;
        slot_next      = slot;
        frame_end_next = 1'b0;
        mem_rd         = 1'b0;
        mem_we         = 1'b0;
        cpu_ack        = 1'b0;
        mem_address    = {slot, tg_wave_address};

        if (enable) begin
            case (phase)
                PH_ACCESS: begin
                    phase_next = PH_DATA;
                    mem_rd     = 1'b1;
                end
                PH_DATA: begin
                    phase_next     = PH_ACCESS;
                    slot_next      = (slot == LAST_SLOT) ? '0 : slot + CH_BITS'(1);
                    frame_end_next = (slot == LAST_SLOT);
                end
                default: begin
                    phase_next = PH_ACCESS;
                end
            endcase
        end

        if (cpu_grant) begin
            cpu_ack     = 1'b1;
            mem_we      = cpu_we;
            mem_address = cpu_address;
        end
    end

    // ------------------------------------------------------------------------
    // Slot mux: current channel's config and stored state to the generator
    // ------------------------------------------------------------------------
    always_comb begin
        tg_reg_wave_length     = 2'd0;
        tg_reg_frequency_count = 12'd0;
        tg_wave_address_in     = 7'd0;
        tg_frequency_count_in  = 12'd0;
        for (int i = 0; i < NUM_CH; i++) begin
            if (slot == CH_BITS'(i)) begin
                tg_reg_wave_length     = reg_wave_length[2*i +: 2];
                tg_reg_frequency_count = reg_frequency_count[12*i +: 12];
                tg_wave_address_in     = addr_flat[7*i +: 7];
                tg_frequency_count_in  = cnt_flat[12*i +: 12];
            end
        end
    end

    // ------------------------------------------------------------------------
    // Per-channel state, sample latch and half-timing pulse
    // ------------------------------------------------------------------------
    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
            logic [6:0]  wave_addr;
            logic [11:0] freq_cnt;
            logic [7:0]  sample;
            logic        half;
            logic        serviced;

            assign serviced = enable && (slot == CH_BITS'(i));

            always_ff @(posedge clk or negedge nreset) begin
                if (!nreset) begin
                    wave_addr <= 7'd0;
                    freq_cnt  <= 12'd0;
                    sample    <= 8'd0;
                    half      <= 1'b0;
                end else begin
                    half <= 1'b0;
                    if (serviced && (phase == PH_ACCESS)) begin
                        // A keyed-off channel is parked at zero so it
                        // restarts from the top of its wave on key-on.
                        if (reg_key_on[i]) begin
                            wave_addr <= tg_wave_address_out;
                            freq_cnt  <= tg_frequency_count_out;
                        end else begin
                            wave_addr <= 7'd0;
                            freq_cnt  <= 12'd0;
                        end
                        half <= tg_half_timing & reg_key_on[i];
                    end
                    if (serviced && (phase == PH_DATA)) begin
                        sample <= reg_key_on[i] ? mem_rdata : 8'h00;
                    end
                end
            end

            assign addr_flat[7*i +: 7]    = wave_addr;
            assign cnt_flat[12*i +: 12]   = freq_cnt;
            assign ch_sample[8*i +: 8]    = sample;
            assign ch_half[i]             = half;
        end
    endgenerate

endmodule
`default_nettype wire

// File: tb/tb_wts_channel_scheduler.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
//  Module      : tb_wts_channel_scheduler
//  Description : Self-checking bench for wts_channel_scheduler. Provides a
//                simple tone-generator model and a wave memory; expected
//                reads, grants, frame samples and half pulses are queued by
//                the stimulus and consumed by an independent monitor.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_wts_channel_scheduler;

    localparam int NUM_CH  = 5;
    localparam int CH_BITS = 3;
    localparam int AW      = CH_BITS + 7;

    logic                 clk = 1'b0;
    logic                 nreset = 1'b0;
    logic                 enable = 1'b0;
    logic [NUM_CH-1:0]    reg_key_on = '0;
    logic [2*NUM_CH-1:0]  reg_wave_length = '0;
    logic [12*NUM_CH-1:0] reg_frequency_count = '0;
    logic [1:0]           tg_reg_wave_length;
    logic [11:0]          tg_reg_frequency_count;
    logic [6:0]           tg_wave_address_in;
    logic [11:0]          tg_frequency_count_in;
    logic [6:0]           tg_wave_address_out;
    logic [11:0]          tg_frequency_count_out;
    logic [6:0]           tg_wave_address;
    logic                 tg_half_timing;
    logic [AW-1:0]        mem_address;
    logic                 mem_rd;
    logic                 mem_we;
    logic [7:0]           mem_rdata = 8'd0;
    logic                 cpu_req = 1'b0;
    logic                 cpu_we = 1'b0;
    logic [AW-1:0]        cpu_address = '0;
    logic                 cpu_ack;
    logic [8*NUM_CH-1:0]  ch_sample;
    logic [NUM_CH-1:0]    ch_half;
    logic                 frame_end;

    wts_channel_scheduler #(.NUM_CH(NUM_CH), .CH_BITS(CH_BITS)) dut (
        .clk                    (clk),
        .nreset                 (nreset),
        .enable                 (enable),
        .reg_key_on             (reg_key_on),
        .reg_wave_length        (reg_wave_length),
        .reg_frequency_count    (reg_frequency_count),
        .tg_reg_wave_length     (tg_reg_wave_length),
        .tg_reg_frequency_count (tg_reg_frequency_count),
        .tg_wave_address_in     (tg_wave_address_in),
        .tg_frequency_count_in  (tg_frequency_count_in),
        .tg_wave_address_out    (tg_wave_address_out),
        .tg_frequency_count_out (tg_frequency_count_out),
        .tg_wave_address        (tg_wave_address),
        .tg_half_timing         (tg_half_timing),
        .mem_address            (mem_address),
        .mem_rd                 (mem_rd),
        .mem_we                 (mem_we),
        .mem_rdata              (mem_rdata),
        .cpu_req                (cpu_req),
        .cpu_we                 (cpu_we),
        .cpu_address            (cpu_address),
        .cpu_ack                (cpu_ack),
        .ch_sample              (ch_sample),
        .ch_half                (ch_half),
        .frame_end              (frame_end)
    );

    always #5 clk = ~clk;

    // Tone generator: counter runs 0..terminal, then the wave address steps
    // within a 16/32/64/128-entry window; half pulse on the window wrap.
    logic [6:0] gen_mask;
    logic       gen_adv;
    always_comb begin
        gen_mask               = 7'h7F >> (2'd3 - tg_reg_wave_length);
        gen_adv                = (tg_frequency_count_in >= tg_reg_frequency_count);
        tg_frequency_count_out = gen_adv ? 12'd0 : tg_frequency_count_in + 12'd1;
        tg_wave_address_out    = gen_adv ? ((tg_wave_address_in + 7'd1) & gen_mask)
                                         : (tg_wave_address_in & gen_mask);
        tg_wave_address        = tg_wave_address_in & gen_mask;
        tg_half_timing         = gen_adv && ((tg_wave_address_in & gen_mask) == gen_mask);
    end

    // Wave memory: read data valid on the clock after mem_rd.
    logic [7:0] mem [0:(1<<AW)-1];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem[mem_address];
    end

    // Scoreboard
    logic [AW-1:0]       rd_q   [$];
    logic [AW:0]         ack_q  [$];
    logic [8*NUM_CH-1:0] fe_q   [$];
    logic [NUM_CH-1:0]   half_q [$];
    logic rd_chk  = 1'b0;
    logic fe_chk  = 1'b0;
    logic per_chk = 1'b0;
    int   n_cmp   = 0;
    int   n_bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic unexpected(input string name, input logic [63:0] act);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: got 0x%0h with nothing expected at %0t", name, act, $time);
    endtask

    // Monitor: samples mid-cycle on the falling edge.
    initial begin
        int   cyc;
        int   last_fe;
        logic prev_rd;
        cyc     = 0;
        last_fe = -1;
        prev_rd = 1'b0;
        forever begin
            @(negedge clk);
            if (nreset) begin
                if (rd_chk) begin
                    check("rd_alternate", 64'(mem_rd), 64'(!prev_rd));
                    if (mem_rd) begin
                        if (rd_q.size() == 0) unexpected("rd_addr", 64'(mem_address));
                        else check("rd_addr", 64'(mem_address), 64'(rd_q.pop_front()));
                    end
                end
                if (cpu_ack) begin
                    check("ack_vs_rd", 64'(mem_rd), 64'(0));
                    if (ack_q.size() == 0) unexpected("ack", 64'({mem_we, mem_address}));
                    else check("ack_we_addr", 64'({mem_we, mem_address}), 64'(ack_q.pop_front()));
                end
                if (frame_end) begin
                    if (per_chk && last_fe >= 0) check("frame_period", 64'(cyc - last_fe), 64'(10));
                    last_fe = cyc;
                    if (fe_chk) begin
                        if (fe_q.size() == 0) unexpected("frame_sample", 64'(ch_sample));
                        else check("frame_sample", 64'(ch_sample), 64'(fe_q.pop_front()));
                    end
                end
                if (ch_half != '0) begin
                    if (half_q.size() == 0) unexpected("ch_half", 64'(ch_half));
                    else check("ch_half", 64'(ch_half), 64'(half_q.pop_front()));
                end
                prev_rd = mem_rd;
                cyc++;
            end
        end
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Channel 0 is keyed on at frame 8, off at 17, on again at 18.
    function automatic int ch0_addr(input int k);
        if (k < 8)        return 0;
        else if (k <= 16) return k - 8;
        else if (k == 17) return 9;
        else              return k - 18;
    endfunction

    task automatic push_frame(input int k);
        logic [8*NUM_CH-1:0] smp;
        int a0, a1, a2;
        a0 = ch0_addr(k);
        a1 = k / 3;
        a2 = k % 16;
        rd_q.push_back({3'd0, 7'(a0)});
        rd_q.push_back({3'd1, 7'(a1)});
        rd_q.push_back({3'd2, 7'(a2)});
        rd_q.push_back({3'd3, 7'd0});
        rd_q.push_back({3'd4, 7'd0});
        smp = '0;
        smp[7:0]   = (k >= 8 && k != 17) ? 8'hC0 + 8'(a0) : 8'h00;
        smp[15:8]  = 8'h40 + 8'(a1);
        smp[23:16] = 8'h80 + 8'(a2);
        fe_q.push_back(smp);
        if (k == 15) half_q.push_back(5'b00100);
    endtask

    initial begin
        for (int n = 0; n < (1 << AW); n++) mem[n] = 8'h11;
        for (int n = 0; n < 32; n++) begin
            mem[{3'd0, 7'(n)}] = 8'hC0 + 8'(n);
            mem[{3'd1, 7'(n)}] = 8'h40 + 8'(n);
            mem[{3'd2, 7'(n)}] = 8'h80 + 8'(n);
        end
        reg_wave_length[1:0]       = 2'd1;
        reg_frequency_count[11:0]  = 12'd0;
        reg_frequency_count[23:12] = 12'd2;
        reg_frequency_count[35:24] = 12'd0;

        // Reset
        repeat (3) tick();
        nreset = 1'b1;
        #1;
        check("rst_ch_sample", 64'(ch_sample), 64'(0));
        check("rst_ch_half", 64'(ch_half), 64'(0));
        check("rst_frame_end", 64'(frame_end), 64'(0));
        check("rst_mem_rd", 64'(mem_rd), 64'(0));
        check("rst_cpu_ack", 64'(cpu_ack), 64'(0));
        check("rst_state", 64'({tg_wave_address_in, tg_frequency_count_in}), 64'(0));

        // Sweep with all channels keyed off
        tick();
        enable  = 1'b1;
        rd_chk  = 1'b1;
        fe_chk  = 1'b1;
        per_chk = 1'b1;
        for (int f = 0; f < 3; f++) begin
            for (int s = 0; s < NUM_CH; s++) rd_q.push_back({3'(s), 7'd0});
            fe_q.push_back('0);
        end
        #1;
        check("first_rd", 64'(mem_rd), 64'(1));
        check("first_addr", 64'(mem_address), 64'(0));
        repeat (30) tick();

        // Advance, data path and key-off/resume
        for (int k = 0; k < 20; k++) begin
            if (k == 0)  reg_key_on = 5'b00110;
            if (k == 8)  reg_key_on[0] = 1'b1;
            if (k == 17) reg_key_on[0] = 1'b0;
            if (k == 18) reg_key_on[0] = 1'b1;
            push_frame(k);
            repeat (10) tick();
        end
        rd_chk = 1'b0;
        tick();
        fe_chk = 1'b0;
        tick();

        // CPU arbitration: request in ACCESS slot 1, grant in DATA
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_address = {3'd3, 7'h25};
        ack_q.push_back({1'b1, 3'd3, 7'h25});
        #1;
        check("no_ack_in_access", 64'(cpu_ack), 64'(0));
        tick();
        tick();
        // Held request across two slots: one grant per DATA phase
        cpu_we      = 1'b0;
        cpu_address = {3'd1, 7'h5A};
        ack_q.push_back({1'b0, 3'd1, 7'h5A});
        ack_q.push_back({1'b0, 3'd1, 7'h5A});
        repeat (4) tick();

        // Frozen sweep at ACCESS slot 4: CPU granted immediately
        cpu_req = 1'b0;
        enable  = 1'b0;
        per_chk = 1'b0;
        #1;
        check("frozen_mem_rd", 64'(mem_rd), 64'(0));
        tick();
        cpu_req     = 1'b1;
        cpu_we      = 1'b1;
        cpu_address = {3'd4, 7'h7F};
        ack_q.push_back({1'b1, 3'd4, 7'h7F});
        ack_q.push_back({1'b1, 3'd4, 7'h7F});
        #1;
        check("frozen_ack", 64'(cpu_ack), 64'(1));
        repeat (2) tick();

        // Resume from the held slot
        cpu_req = 1'b0;
        enable  = 1'b1;
        rd_chk  = 1'b1;
        rd_q.push_back({3'd4, 7'd0});
        rd_q.push_back({3'd0, 7'd3});
        repeat (4) tick();
        rd_chk = 1'b0;
        repeat (5) tick();

        if (rd_q.size() != 0)   unexpected("rd_left", 64'(rd_q.size()));
        if (ack_q.size() != 0)  unexpected("ack_left", 64'(ack_q.size()));
        if (fe_q.size() != 0)   unexpected("frame_left", 64'(fe_q.size()));
        if (half_q.size() != 0) unexpected("half_left", 64'(half_q.size()));

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
